// File: rtl/cpu_pkg.sv
// Shared widths and the store-buffer entry record used by the core's data-side blocks.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [ADDR_W-3:0] widx;
    logic [DATA_W-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// Load-forwarding lookup: scans from the youngest entry (wr_ptr-1) back to the oldest
// and returns the data of the first valid entry whose word index matches.
module sb_fwd_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     wr_ptr,
  input  logic [ADDR_W-3:0] widx,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PW-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = wr_ptr - PW'(k + 1);
      if (!hit && valid[idx] && (entries[idx].widx == widx)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and data memory, with youngest-match
// load forwarding so the core always observes its own stores in program order.
module store_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = ADDR_W,
  parameter int DW    = DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic [AW-1:0] DataAdr,
  input  logic [DW-1:0] WriteData,
  output logic [DW-1:0] ReadData,
  output logic          Stall,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t        entries [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             full;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] valid;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = MemWrite & ~full;
  assign Stall = MemWrite & full;

  // Memory handshake: mem_req is high while the head entry is pending and the
  // request fields hold steady; the entry is retired on any cycle with mem_req & mem_ack.
  assign mem_req   = ~empty;
  assign pop       = mem_req & mem_ack;
  assign mem_addr  = {entries[rd_ptr].widx, 2'b00};
  assign mem_wdata = entries[rd_ptr].data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr].widx <= DataAdr[AW-1:2];
      entries[wr_ptr].data <= WriteData;
    end
  end

  // An entry is live when its distance from the head is below count, which keeps
  // the head valid for forwarding during the cycle it is being popped.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PW'(i) - rd_ptr} < count);
    end
  end

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .entries (entries),
    .valid   (valid),
    .wr_ptr  (wr_ptr),
    .widx    (DataAdr[AW-1:2]),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  assign ReadData = fwd_hit ? fwd_data : mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a cycle table of inputs and hand-computed outputs,
// a memory-side drain scoreboard, and hand-written reset sequences.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        chk_read;
    logic [31:0] exp_read;
    logic        exp_stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_empty;
  } vec_t;

  vec_t vecs[$];

  store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .empty     (empty)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mw, input logic [31:0] adr, input logic [31:0] wdata,
                              input logic ack, input logic [31:0] rdata,
                              input logic chk_read, input logic [31:0] exp_read,
                              input logic exp_stall, input logic exp_req,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              input logic exp_empty);
    vec_t v;
    v.mw = mw; v.adr = adr; v.wdata = wdata; v.ack = ack; v.rdata = rdata;
    v.chk_read = chk_read; v.exp_read = exp_read; v.exp_stall = exp_stall;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
    v.exp_empty = exp_empty;
    return v;
  endfunction

  // Driver: inputs change on the falling edge
  task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] wdata,
                       input logic ack, input logic [31:0] rdata);
    MemWrite  = mw;
    DataAdr   = adr;
    WriteData = wdata;
    mem_ack   = ack;
    mem_rdata = rdata;
  endtask

  // Scoreboard: every write the memory accepts must be the oldest expected store
  always @(posedge clk) begin
    if (reset && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain_extra: got 0x%0h/0x%0h with nothing expected", mem_addr, mem_wdata);
      end else begin
        check("drain_order", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  initial begin
    vec_t v;
    drive(1'b1, 32'd100, 32'd9, 1'b0, 32'h0);
    reset = 1'b0;

    //        mw  adr  wdata ack rdata        chk rd           stall req addr wdata empty
    vecs.push_back(mk(0, 104, 0, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0, 0,   0, 1));
    vecs.push_back(mk(1, 100, 7, 0, 32'h0,        1, 32'h0,        0, 0, 0,   0, 1));
    vecs.push_back(mk(0, 100, 0, 0, 32'h0,        1, 32'd7,        0, 1, 100, 7, 0));
    vecs.push_back(mk(0, 101, 0, 0, 32'h55,       1, 32'd7,        0, 1, 100, 7, 0));
    vecs.push_back(mk(0, 100, 0, 1, 32'h11,       1, 32'd7,        0, 1, 100, 7, 0));
    vecs.push_back(mk(0, 100, 0, 0, 32'h11,       1, 32'h11,       0, 0, 0,   0, 1));
    vecs.push_back(mk(1, 84,  1, 0, 32'h0,        0, 32'h0,        0, 0, 0,   0, 1));
    vecs.push_back(mk(1, 88,  2, 0, 32'h0,        0, 32'h0,        0, 1, 84,  1, 0));
    vecs.push_back(mk(1, 92,  3, 0, 32'h0,        0, 32'h0,        0, 1, 84,  1, 0));
    vecs.push_back(mk(1, 96,  4, 0, 32'h0,        0, 32'h0,        0, 1, 84,  1, 0));
    vecs.push_back(mk(1, 100, 5, 0, 32'h0,        0, 32'h0,        1, 1, 84,  1, 0));
    vecs.push_back(mk(1, 100, 5, 1, 32'h0,        0, 32'h0,        1, 1, 84,  1, 0));
    vecs.push_back(mk(1, 100, 5, 1, 32'h0,        0, 32'h0,        0, 1, 88,  2, 0));
    vecs.push_back(mk(0, 0,   0, 1, 32'h0,        0, 32'h0,        0, 1, 92,  3, 0));
    vecs.push_back(mk(0, 0,   0, 1, 32'h0,        0, 32'h0,        0, 1, 96,  4, 0));
    vecs.push_back(mk(0, 100, 0, 1, 32'h0,        1, 32'd5,        0, 1, 100, 5, 0));
    vecs.push_back(mk(0, 100, 0, 0, 32'h42,       1, 32'h42,       0, 0, 0,   0, 1));
    vecs.push_back(mk(1, 96,  1, 0, 32'h0,        0, 32'h0,        0, 0, 0,   0, 1));
    vecs.push_back(mk(1, 96,  2, 0, 32'h0,        0, 32'h0,        0, 1, 96,  1, 0));
    vecs.push_back(mk(0, 96,  0, 0, 32'h99,       1, 32'd2,        0, 1, 96,  1, 0));
    vecs.push_back(mk(0, 96,  0, 1, 32'h99,       1, 32'd2,        0, 1, 96,  1, 0));
    vecs.push_back(mk(0, 96,  0, 0, 32'h99,       1, 32'd2,        0, 1, 96,  2, 0));
    vecs.push_back(mk(0, 96,  0, 1, 32'h99,       1, 32'd2,        0, 1, 96,  2, 0));
    vecs.push_back(mk(0, 96,  0, 0, 32'h99,       1, 32'h99,       0, 0, 0,   0, 1));
    vecs.push_back(mk(1, 200, 10, 0, 32'h0,       0, 32'h0,        0, 0, 0,   0, 1));
    vecs.push_back(mk(1, 204, 11, 0, 32'h0,       0, 32'h0,        0, 1, 200, 10, 0));
    vecs.push_back(mk(1, 208, 12, 1, 32'h0,       0, 32'h0,        0, 1, 200, 10, 0));
    vecs.push_back(mk(0, 208, 0, 0, 32'h0,        1, 32'd12,       0, 1, 204, 11, 0));
    vecs.push_back(mk(0, 0,   0, 1, 32'h0,        0, 32'h0,        0, 1, 204, 11, 0));
    vecs.push_back(mk(0, 204, 0, 1, 32'h77,       1, 32'h77,       0, 1, 208, 12, 0));
    vecs.push_back(mk(0, 0,   0, 1, 32'h0,        0, 32'h0,        0, 0, 0,   0, 1));
    vecs.push_back(mk(1, 300, 51, 1, 32'h0,       0, 32'h0,        0, 0, 0,   0, 1));
    vecs.push_back(mk(0, 300, 0, 0, 32'h0,        1, 32'd51,       0, 1, 300, 51, 0));

    // Reset state, with a store strobe present
    #3;
    check("rst_req",   mem_req, 1'b0);
    check("rst_empty", empty,   1'b1);
    check("rst_stall", Stall,   1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.mw, v.adr, v.wdata, v.ack, v.rdata);
      if (v.mw && !v.exp_stall) exp_q.push_back({v.adr & 32'hFFFF_FFFC, v.wdata});
      #1;
      if (v.chk_read) check($sformatf("v%0d_read", i), ReadData, v.exp_read);
      check($sformatf("v%0d_stall", i), Stall,   v.exp_stall);
      check($sformatf("v%0d_req", i),   mem_req, v.exp_req);
      check($sformatf("v%0d_empty", i), empty,   v.exp_empty);
      if (v.exp_req) begin
        check($sformatf("v%0d_addr", i),  mem_addr,  v.exp_addr);
        check($sformatf("v%0d_wdata", i), mem_wdata, v.exp_wdata);
      end
      @(negedge clk);
    end

    // Fill to three pending entries, then reset asynchronously between edges
    drive(1'b1, 32'd304, 32'd1, 1'b0, 32'h0);
    exp_q.push_back({32'd304, 32'd1});
    @(negedge clk);
    drive(1'b1, 32'd308, 32'd2, 1'b0, 32'h0);
    exp_q.push_back({32'd308, 32'd2});
    @(negedge clk);
    drive(1'b1, 32'd400, 32'd3, 1'b0, 32'h0);
    #1;
    check("pre_rst_req", mem_req, 1'b1);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_req",   mem_req, 1'b0);
    check("mid_rst_empty", empty,   1'b1);
    check("mid_rst_stall", Stall,   1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 32'd100, 32'd7, 1'b0, 32'h0);
    exp_q.push_back({32'd100, 32'd7});
    #1;
    check("post_rst_req0", mem_req, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'h0);
    #1;
    check("post_rst_req1",   mem_req,   1'b1);
    check("post_rst_addr",   mem_addr,  32'd100);
    check("post_rst_wdata",  mem_wdata, 32'd7);
    check("post_rst_empty",  empty,     1'b0);

    // Drain whatever remains, bounded
    @(negedge clk);
    mem_ack = 1'b1;
    for (int i = 0; i < 8 && !empty; i++) @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("final_empty", empty, 1'b1);
    check("final_q", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-wide posted-write buffer between the single-cycle core's data port (MemWrite/DataAdr/WriteData) and the data memory.
- Core stores retire in one cycle into a small FIFO. The FIFO drains to memory over a req/ack handshake, so a slow memory stalls the core only when the FIFO is full.
- Loads check the buffer first; the youngest matching entry forwards its data, keeping memory ordering exact for the core.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  core store strobe for the current instruction.
- DataAdr  in  AW  core data address; bits [1:0] ignored (word-aligned).
- WriteData  in  DW  core store data.
- ReadData  out  DW  load data to core; combinational.
- Stall  out  1  core must hold PC and the current instruction.
- mem_req  out  1  head entry valid, write request to memory.
- mem_addr  out  AW  head entry address, {addr[AW-1:2],2'b00}.
- mem_wdata  out  DW  head entry data.
- mem_ack  in  1  memory accepted the head entry this cycle.
- mem_rdata  in  DW  memory combinational read data at DataAdr.
- empty  out  1  no entries pending (fence/debug visibility).

Behaviour:
- Storage: DEPTH entries {addr word index, data}. Pointers wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Reset (reset=0, async): wr_ptr=0, rd_ptr=0, count=0, mem_req=0, Stall=0, empty=1. Entry contents are don't-care.
- Reset mid-drain: pending entries are discarded. Memory must ignore the in-flight request once reset asserts.
- push = MemWrite & (count != DEPTH). On push, {DataAdr[AW-1:2], WriteData} is written at wr_ptr on the clk rising edge and wr_ptr increments.
- Stall = MemWrite & (count == DEPTH). Stall depends only on the registered count; mem_ack in the same cycle does not release it. The store is accepted the following cycle.
- Drain:
  - mem_req = (count != 0); mem_addr and mem_wdata come from the rd_ptr entry.
  - pop = mem_req & mem_ack; on pop, rd_ptr increments.
  - mem_req, mem_addr and mem_wdata stay stable until ack.
  - mem_ack while count==0 is ignored.
- Count update:
  - push & pop: count unchanged.
  - push only: count+1.
  - pop only: count-1.
- Ordering: memory sees stores in program order, one per ack, maximum throughput one per cycle.
- Load forwarding (combinational, MemWrite=0):
  - Compare DataAdr[AW-1:2] against every valid entry.
  - On hit, ReadData = data of the youngest matching entry (closest to wr_ptr-1).
  - On miss, ReadData = mem_rdata.
  - The entry being popped this cycle is still valid for forwarding.
- Write-after-write to the same address creates a new entry; no coalescing.
- empty = (count == 0).
- Latency: store-to-mem_req minimum 1 cycle (entry visible the cycle after push). Load-hit forwarding has 0 cycles of latency.

Decomposition:
- Shared package (cpu_pkg): DATA_W=32, ADDR_W=32 constants, and a typedef sb_entry_t {logic [ADDR_W-3:0] widx; logic [DATA_W-1:0] data}.
- One sub-module: sb_fwd_match. Purely combinational; takes the entry array plus valid mask and returns hit and youngest-hit data via a priority scan from wr_ptr-1 backwards.
- FIFO control and pointers stay in store_buffer.

Test Plan:
- Store 7 to addr 100, mem_ack held 0, then load addr 100 -> ReadData=7 with mem_rdata=0; mem_req=1, mem_addr=100, mem_wdata=7.
- Stores to 84, 88, 92, 96 (data 1..4) with mem_ack=0, then a 5th store to 100 -> Stall=1 only during the 5th. Pulse mem_ack for 4 cycles -> memory sees 84, 88, 92, 96 in order. The 5th accepted with Stall=0 one cycle after the first ack; empty=1 after all drain.
- Stores 96<-1 then 96<-2 (no ack), then load 96 -> ReadData=2. Ack once, load 96 -> still 2. Ack again -> miss, ReadData=mem_rdata.
- count=2, MemWrite=1 with mem_ack=1 in the same cycle -> count stays 2, head advances, new entry at tail.
- count=3 mid-drain, assert reset=0 asynchronously between edges -> mem_req=0, empty=1, Stall=0 immediately. After release, store 7 to 100 -> mem_req next cycle with addr 100.
- Load addr 104 with empty buffer, mem_rdata=0xDEADBEEF -> ReadData=0xDEADBEEF; load addr 101 after store 100<-7 -> hit, ReadData=7 (bits [1:0] ignored).
